// File: rtl/ratio_clk_detect.sv
// ratio_clk_detect
// Receive-side ratio detector for the ratio-clock subsystem. Measures the
// half-period of div_clk_i in clk_i cycles, decodes the divide exponent r
// (half-period = 2^r) and reports it once LOCK_COUNT consecutive matching
// measurements have been seen.
//
// Optional build macro RATIO_CLK_DETECT_SYNC_EN: when defined, div_clk_i passes
// through a 2-flop synchronizer before edge detection (for an unrelated or
// skewed source). This adds 2 cycles of edge latency but does not change the
// measured lengths. When undefined, div_clk_i must be synchronous to clk_i.
module ratio_clk_detect #(
    parameter int RATIO_GRADE = 3,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   en_i,
    input  logic                   div_clk_i,
    output logic [RATIO_GRADE-1:0] ratio_o,
    output logic                   locked_o,
    output logic                   err_o
);

    // W is the half-period counter width; the longest decodable half-period is 2^(W-1)
    localparam int W  = 1 << RATIO_GRADE;
    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]  ONE_L = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  MAX_L = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  TMO_L = MAX_L + ONE_L;
    localparam logic [MW:0]   LC_V  = (MW+1)'(LOCK_COUNT);
    localparam logic [MW:0]   ONE_M = {{MW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SEARCH,
        LOCKED
    } state_t;

    state_t                 state;
    logic                   s_in;
    logic                   s_q;
    logic                   s_prev;
    logic                   edge_det;
    logic [W-1:0]           hp_cnt;
    logic [MW-1:0]          match_cnt;
    logic [RATIO_GRADE-1:0] cand;
    logic                   meas_valid;
    logic [RATIO_GRADE-1:0] meas_r;
    logic                   timeout;
    logic [MW:0]            match_inc;
    logic [MW:0]            match_new;
    logic                   lock_hit;

`ifdef RATIO_CLK_DETECT_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer for a div_clk_i that is not timed against clk_i
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= div_clk_i;
            sync2_q <= sync1_q;
        end
    end

    assign s_in = sync2_q;
`else
    assign s_in = div_clk_i;
`endif

    // Sample flops keep running even while disabled so re-enabling sees no stale edge
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s_q    <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_q    <= s_in;
            s_prev <= s_q;
        end
    end

    assign edge_det = s_q ^ s_prev;

    // A half-period is usable only if it is an exact power of two within range
    assign meas_valid = (hp_cnt != '0) && ((hp_cnt & (hp_cnt - ONE_L)) == '0) && (hp_cnt <= MAX_L);
    assign timeout    = (hp_cnt == TMO_L) && !edge_det;

    // Position of the single set bit gives log2 of the measured half-period
    always_comb begin
        meas_r = '0;
        for (int i = 0; i < W; i++) begin
            if (hp_cnt[i]) begin
                meas_r = RATIO_GRADE'(i);
            end
        end
    end

    // Next agreement count while searching: extend the run or restart it at one
    always_comb begin
        match_inc = {1'b0, match_cnt} + ONE_M;
        match_new = ((match_cnt == '0) || (meas_r == cand)) ? match_inc : ONE_M;
        lock_hit  = (match_new >= LC_V);
    end

    // Detector FSM with half-period counter, agreement counter and registered outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            hp_cnt    <= '0;
            match_cnt <= '0;
            cand      <= '0;
            ratio_o   <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else if (!en_i) begin
            state     <= IDLE;
            hp_cnt    <= '0;
            match_cnt <= '0;
            cand      <= '0;
            ratio_o   <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o  <= 1'b0;
            hp_cnt <= edge_det ? ONE_L : hp_cnt + ONE_L;
            case (state)
                IDLE: begin
                    state <= ARM;
                end
                ARM: begin
                    if (edge_det) begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                    end
                end
                SEARCH: begin
                    if (edge_det) begin
                        if (meas_valid) begin
                            cand <= meas_r;
                            if (lock_hit) begin
                                state     <= LOCKED;
                                match_cnt <= LC_V[MW-1:0];
                                ratio_o   <= meas_r;
                                locked_o  <= 1'b1;
                            end else begin
                                match_cnt <= match_new[MW-1:0];
                            end
                        end else begin
                            match_cnt <= '0;
                            err_o     <= 1'b1;
                        end
                    end else if (timeout) begin
                        state     <= ARM;
                        match_cnt <= '0;
                        err_o     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (!(meas_valid && (meas_r == ratio_o))) begin
                            state    <= SEARCH;
                            locked_o <= 1'b0;
                            err_o    <= 1'b1;
                            if (meas_valid) begin
                                cand      <= meas_r;
                                match_cnt <= ONE_M[MW-1:0];
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                    end else if (timeout) begin
                        state     <= ARM;
                        locked_o  <= 1'b0;
                        match_cnt <= '0;
                        err_o     <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ratio_clk_detect.sv
// tb_ratio_clk_detect
// Self-checking bench for ratio_clk_detect (RATIO_GRADE=3, LOCK_COUNT=4).
// The bench drives div_clk_i as a list of toggle instants and predicts the
// outputs from the measured half-periods between those instants.
module tb_ratio_clk_detect;

    localparam int RG    = 3;
    localparam int LC    = 4;
    localparam int W     = 1 << RG;
    localparam int MAX_L = 1 << (W - 1);
    localparam int TMO   = MAX_L + 1;
`ifdef RATIO_CLK_DETECT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int hp_a;
        int hp_b;
        int n;
        bit exp_locked;
        int exp_ratio;
        int exp_errs;
    } vec_t;

    logic          clk;
    logic          arst_n;
    logic          en;
    logic          div_clk;
    logic [RG-1:0] ratio;
    logic          locked;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_toggle = 0;

    // reference model: toggle-instant view of the detector
    int m_phase;
    int m_last;
    int m_streak;
    int m_streak_r;
    bit m_locked;
    int m_ratio;
    bit m_err;
    bit dl_locked[8];
    int dl_ratio[8];
    bit dl_err[8];

    bit sched[$];
    int cp_step[$];
    int cp_idx[$];
    vec_t vecs[8];

    ratio_clk_detect #(
        .RATIO_GRADE(RG),
        .LOCK_COUNT (LC)
    ) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .en_i     (en),
        .div_clk_i(div_clk),
        .ratio_o  (ratio),
        .locked_o (locked),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isValid(input int len);
        bit pow2 = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (len == (1 << k)) pow2 = 1'b1;
        end
        return pow2 && (len <= MAX_L);
    endfunction

    function automatic int log2i(input int len);
        int r = 0;
        while ((1 << (r + 1)) <= len) r++;
        return r;
    endfunction

    function automatic void modelRestart();
        m_phase    = 1;
        m_last     = 0;
        m_streak   = 0;
        m_streak_r = 0;
        m_locked   = 1'b0;
        m_ratio    = 0;
        m_err      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dl_locked[i] = 1'b0;
            dl_ratio[i]  = 0;
            dl_err[i]    = 1'b0;
        end
    endfunction

    function automatic void modelEdge(input int len);
        bit v;
        int r;
        v = isValid(len);
        r = v ? log2i(len) : 0;
        if (m_locked) begin
            if (!(v && r == m_ratio)) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
                if (v) begin
                    m_streak   = 1;
                    m_streak_r = r;
                end else begin
                    m_streak = 0;
                end
            end
        end else if (!v) begin
            m_err    = 1'b1;
            m_streak = 0;
        end else begin
            if (m_streak == 0 || r == m_streak_r) m_streak++;
            else m_streak = 1;
            m_streak_r = r;
            if (m_streak >= LC) begin
                m_locked = 1'b1;
                m_ratio  = r;
            end
        end
    endfunction

    function automatic void modelStep(input int t, input bit tog);
        int idx;
        m_err = 1'b0;
        if (m_phase == 1 && tog) begin
            m_phase = 2;
            m_last  = t;
        end else if (m_phase == 2) begin
            if (tog) begin
                modelEdge(t - m_last);
                m_last = t;
            end else if (t - m_last == TMO) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
                m_streak = 0;
                m_phase  = 1;
            end
        end
        idx = (t + LAT) % 8;
        dl_locked[idx] = m_locked;
        dl_ratio[idx]  = m_ratio;
        dl_err[idx]    = m_err;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one clk_i step: optional toggle, model update, compare at the falling edge
    task automatic applyStimulus(input bit tog);
        @(posedge clk);
        #1;
        cyc++;
        if (tog) begin
            div_clk = ~div_clk;
            last_toggle = cyc;
        end
        modelStep(cyc, tog);
        @(negedge clk);
        checkOutput($sformatf("locked@%0d", cyc), int'(locked), int'(dl_locked[cyc % 8]));
        checkOutput($sformatf("ratio@%0d", cyc), int'(ratio), dl_ratio[cyc % 8]);
        checkOutput($sformatf("err@%0d", cyc), int'(err), int'(dl_err[cyc % 8]));
    endtask

    task automatic driveToggles(input int hp, input int n);
        for (int j = 0; j < n; j++) begin
            applyStimulus(1'b1);
            for (int k = 1; k < hp; k++) applyStimulus(1'b0);
        end
    endtask

    function automatic int addToggles(input int a, input int b, input int n);
        int last_idx = 0;
        for (int j = 0; j < n; j++) begin
            int sp;
            sched.push_back(1'b1);
            last_idx = sched.size() - 1;
            sp = (j % 2 == 0) ? a : b;
            for (int k = 1; k < sp; k++) sched.push_back(1'b0);
        end
        return last_idx;
    endfunction

    function automatic int pickHp();
        int r = $urandom_range(0, 9);
        if (r < 7) return 1 << $urandom_range(0, 6);
        if (r == 7) return 128;
        return $urandom_range(1, 140);
    endfunction

    task automatic runSchedule();
        int seg_errs = 0;
        int k = 0;
        for (int s = 0; s < sched.size(); s++) begin
            applyStimulus(sched[s]);
            if (err === 1'b1) seg_errs++;
            if (k < cp_step.size() && cp_step[k] == s) begin
                int i = cp_idx[k];
                checkOutput($sformatf("tbl%0d.locked", i), int'(locked), int'(vecs[i].exp_locked));
                checkOutput($sformatf("tbl%0d.ratio", i), int'(ratio), vecs[i].exp_ratio);
                checkOutput($sformatf("tbl%0d.errs", i), seg_errs, vecs[i].exp_errs);
                seg_errs = 0;
                k++;
            end
        end
        sched.delete();
        cp_step.delete();
        cp_idx.delete();
    endtask

    initial begin
        int delay;
        bit seen;

        arst_n  = 1'b0;
        en      = 1'b1;
        div_clk = 1'b0;

        vecs[0] = '{4, 4, 5, 1'b1, 2, 0};
        vecs[1] = '{32, 32, 5, 1'b1, 5, 1};
        vecs[2] = '{32, 32, 3, 1'b1, 5, 0};
        vecs[3] = '{3, 4, 6, 1'b0, 5, 3};
        vecs[4] = '{1, 1, 6, 1'b1, 0, 0};
        vecs[5] = '{128, 128, 6, 1'b1, 7, 1};
        vecs[6] = '{200, 200, 2, 1'b0, 7, 1};
        vecs[7] = '{4, 4, 5, 1'b1, 2, 1};

        @(negedge clk);
        checkOutput("reset.locked", int'(locked), 0);
        checkOutput("reset.ratio", int'(ratio), 0);
        checkOutput("reset.err", int'(err), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        modelRestart();
        repeat (4) applyStimulus(1'b0);

        $display("[TB] table-driven segments");
        for (int i = 0; i < 8; i++) begin
            int last_idx;
            last_idx = addToggles(vecs[i].hp_a, vecs[i].hp_b, vecs[i].n);
            cp_step.push_back(last_idx + LAT);
            cp_idx.push_back(i);
        end
        for (int k = 0; k < LAT; k++) sched.push_back(1'b0);
        runSchedule();

        $display("[TB] randomized segments");
        for (int s = 0; s < 40; s++) begin
            int a;
            int b;
            int n;
            int unused_idx;
            a = pickHp();
            b = ($urandom_range(0, 1) == 0) ? a : pickHp();
            n = $urandom_range(1, 6);
            unused_idx = addToggles(a, b, n);
        end
        runSchedule();

        $display("[TB] timeout after lock");
        driveToggles(4, 6);
        checkOutput("tmo.pre_locked", int'(locked), 1);
        checkOutput("tmo.pre_ratio", int'(ratio), 2);
        seen = 1'b0;
        delay = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            applyStimulus(1'b0);
            if (err === 1'b1) begin
                seen = 1'b1;
                delay = cyc - last_toggle;
            end
        end
        checkOutput("tmo.seen", int'(seen), 1);
        checkOutput("tmo.delay", delay, TMO + LAT);
        applyStimulus(1'b0);
        checkOutput("tmo.locked", int'(locked), 0);

        $display("[TB] async reset while locked");
        driveToggles(4, 6);
        checkOutput("rst.pre_locked", int'(locked), 1);
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("rst.locked", int'(locked), 0);
        checkOutput("rst.ratio", int'(ratio), 0);
        checkOutput("rst.err", int'(err), 0);
        div_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        modelRestart();
        repeat (4) applyStimulus(1'b0);
        driveToggles(4, 4);
        checkOutput("rst.early_locked", int'(locked), 0);
        driveToggles(4, 1);
        repeat (LAT) applyStimulus(1'b0);
        checkOutput("rst.relock", int'(locked), 1);
        checkOutput("rst.relock_ratio", int'(ratio), 2);

        $display("[TB] enable pulsed low while locked");
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        @(negedge clk);
        checkOutput("en.locked", int'(locked), 0);
        checkOutput("en.ratio", int'(ratio), 0);
        checkOutput("en.err", int'(err), 0);
        modelRestart();
        repeat (4) applyStimulus(1'b0);
        driveToggles(4, 4);
        checkOutput("en.early_locked", int'(locked), 0);
        driveToggles(4, 1);
        repeat (LAT) applyStimulus(1'b0);
        checkOutput("en.relock", int'(locked), 1);
        checkOutput("en.relock_ratio", int'(ratio), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
